basic_io_gen: RTL

//  Parametrised memory-mapped on-board I/O block: switches, buttons, LEDs, with interrupt.

---
 rtl/basic_io_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/basic_io_gen.sv
// Memory-mapped board I/O: debounced switches and buttons, LEDs, sticky press latches
// and a maskable interrupt, decoded in a 16-byte window on the CPU byte bus.
module basic_io_gen #(
  parameter int unsigned          ADDR_W    = 6,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          SW_W      = 16,
  parameter int unsigned          BTN_W     = 5,
  parameter int unsigned          LED_W     = 16,
  parameter int unsigned          DB_CYCLES = 1000000,
  parameter int unsigned          DB_STABLE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  input  logic              re,
  input  logic              we,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_W-1:0]  btn,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int unsigned DbW   = SW_W + BTN_W;
  localparam int unsigned TickW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  // Switches and buttons share one synchroniser/debounce pipeline: {btn, sw}
  logic [DbW-1:0]   raw;
  logic [DbW-1:0]   sync1_q, sync2_q;
  logic [DbW-1:0]   deb_q, deb_d;
  logic [3:0]       stab_q [DbW];
  logic [3:0]       stab_d [DbW];
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  logic [SW_W-1:0]  sw_deb_q, sw_deb_d;
  logic [BTN_W-1:0] btn_deb_q, btn_deb_d;

  logic [LED_W-1:0] led_q, led_d;
  logic [BTN_W-1:0] mask_q, mask_d;
  logic [BTN_W-1:0] latch_q, latch_d, latch_clr;
  logic             sw_chg_q, sw_chg_d;
  logic             irq_q, irq_d;

  logic             sel, wr, rd;
  logic [3:0]       off;
  logic [15:0]      led_pad, sw_pad;
  logic [7:0]       rdata;

  assign raw = {btn, sw};

  assign tick       = (tick_cnt_q == TickW'(DB_CYCLES - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < DbW; i++) begin
      stab_d[i] = stab_q[i];
      if (tick) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (stab_q[i] + 4'd1 == 4'(DB_STABLE)) begin
            deb_d[i]  = sync2_q[i];
            stab_d[i] = '0;
          end else begin
            stab_d[i] = stab_q[i] + 4'd1;
          end
        end else begin
          stab_d[i] = '0;
        end
      end
    end
  end

  assign sw_deb_q  = deb_q[SW_W-1:0];
  assign sw_deb_d  = deb_d[SW_W-1:0];
  assign btn_deb_q = deb_q[DbW-1:SW_W];
  assign btn_deb_d = deb_d[DbW-1:SW_W];

  assign sel = (addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign off = addr[3:0];
  assign wr  = sel && we;
  assign rd  = sel && re;

  always_comb begin
    led_pad = 16'(led_q);
    if (wr && off == 4'd4) led_pad[7:0]  = data_in;
    if (wr && off == 4'd5) led_pad[15:8] = data_in;
    led_d = LED_W'(led_pad);

    mask_d    = (wr && off == 4'd6) ? data_in[BTN_W-1:0] : mask_q;
    latch_clr = (wr && off == 4'd3) ? data_in[BTN_W-1:0] : '0;
    // New presses are OR-ed in after the clear so a same-cycle set wins
    latch_d   = (latch_q & ~latch_clr) | (btn_deb_d & ~btn_deb_q);
    sw_chg_d  = (sw_chg_q & ~(wr && off == 4'd7 && data_in[1])) | (sw_deb_d != sw_deb_q);
    irq_d     = |(latch_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      tick_cnt_q <= '0;
      for (int i = 0; i < DbW; i++) stab_q[i] <= '0;
      led_q      <= '0;
      mask_q     <= '0;
      latch_q    <= '0;
      sw_chg_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      tick_cnt_q <= tick_cnt_d;
      for (int i = 0; i < DbW; i++) stab_q[i] <= stab_d[i];
      led_q      <= led_d;
      mask_q     <= mask_d;
      latch_q    <= latch_d;
      sw_chg_q   <= sw_chg_d;
      irq_q      <= irq_d;
    end
  end

  assign sw_pad = 16'(sw_deb_q);

  always_comb begin
    rdata = 8'h00;
    case (off)
      4'd0:    rdata = sw_pad[7:0];
      4'd1:    rdata = sw_pad[15:8];
      4'd2:    rdata = 8'(btn_deb_q);
      4'd3:    rdata = 8'(latch_q);
      4'd4:    rdata = led_pad_rd(led_q, 1'b0);
      4'd5:    rdata = led_pad_rd(led_q, 1'b1);
      4'd6:    rdata = 8'(mask_q);
      4'd7:    rdata = {6'b0, sw_chg_q, irq_q};
      default: rdata = 8'h00;
    endcase
  end

  function automatic logic [7:0] led_pad_rd(input logic [LED_W-1:0] v, input logic hi);
    logic [15:0] p;
    p = 16'(v);
    return hi ? p[15:8] : p[7:0];
  endfunction

  assign data_out = rd ? rdata : 8'h00;
  assign led      = led_q;
  assign irq      = irq_q;

endmodule
